// File: rtl/vga_fb_fetch.sv
// vga_fb_fetch: frame-buffer pixel fetch for the VGA controller.
// Reads a 320x240 RGB565 buffer from async SRAM (pixel doubled to
// 640x480) and slips host writes from a small FIFO into idle slots.
//
// Ports:
//   iCLK, iRST             pixel clock, async active-high reset
//   iCoord_X/Y, iActive    display coordinate and visible flag
//   iWr_Req/Addr/Data      host write request (held until ack)
//   oWr_Ack                one-cycle accept pulse
//   oRed/oGreen/oBlue      10-bit pixel, 3-cycle latency
//   oSRAM_*, iSRAM_DQ      async SRAM interface (DQ tristated above)

module vga_fb_fetch #(
  parameter int FB_W       = 320,
  parameter int FB_H       = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [9:0]  iCoord_X,
  input  logic [9:0]  iCoord_Y,
  input  logic        iActive,
  input  logic        iWr_Req,
  input  logic [17:0] iWr_Addr,
  input  logic [15:0] iWr_Data,
  output logic        oWr_Ack,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic [17:0] oSRAM_ADDR,
  output logic [15:0] oSRAM_DQ_OUT,
  output logic        oSRAM_DQ_OE,
  input  logic [15:0] iSRAM_DQ,
  output logic        oSRAM_CE_N,
  output logic        oSRAM_OE_N,
  output logic        oSRAM_WE_N,
  output logic        oSRAM_UB_N,
  output logic        oSRAM_LB_N
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [17:0] FB_WORDS = 18'(FB_W * FB_H);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE
  } op_e;

  // host write FIFO
  logic [17:0]   fifo_addr_q [FIFO_DEPTH];
  logic [15:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;

  // SRAM cycle registers
  op_e           op_q, op_d;
  logic [17:0]   addr_q, addr_d;
  logic [15:0]   dq_out_q, dq_out_d;
  logic          dq_oe_q, dq_oe_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          ce_n_q;

  // pixel pipeline
  logic          s1_act_q, s2_act_q;
  logic [15:0]   word_q, word_d;
  logic [9:0]    red_q, red_d;
  logic [9:0]    grn_q, grn_d;
  logic [9:0]    blu_q, blu_d;

  logic [8:0]    x_half, y_half;
  logic [16:0]   rd_addr;
  logic          rd_slot;
  logic          fifo_empty, fifo_full;
  logic          push, pop, head_ok;
  logic [17:0]   head_addr;
  logic [15:0]   head_data;

  // Y[0] is dropped by the line doubling
  logic          unused_y0;
  assign unused_y0 = iCoord_Y[0];

  // addr = (Y/2)*320 + X/2, with *320 as (y<<8)+(y<<6)
  always_comb begin
    x_half  = iCoord_X[9:1];
    y_half  = iCoord_Y[9:1];
    rd_addr = {y_half, 8'd0}
            + {2'd0, y_half, 6'd0}
            + {8'd0, x_half};
  end

  always_comb begin
    rd_slot    = iActive & ~iCoord_X[0];
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == DEPTH_C);
    // a request seen during its own ack cycle is ignored
    push       = iWr_Req & ~fifo_full & ~ack_q;
    pop        = ~rd_slot & ~fifo_empty;
    head_addr  = fifo_addr_q[rd_ptr_q];
    head_data  = fifo_data_q[rd_ptr_q];
    head_ok    = (head_addr < FB_WORDS);

    ack_d    = push;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Display read always owns even-X slots; an out-of-range
  // head is still popped but leaves the slot idle.
  always_comb begin
    op_d     = OP_IDLE;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    unique case (1'b1)
      rd_slot: begin
        op_d   = OP_READ;
        addr_d = {1'b0, rd_addr};
        oe_n_d = 1'b0;
      end
      (pop && head_ok): begin
        op_d     = OP_WRITE;
        addr_d   = head_addr;
        dq_out_d = head_data;
        dq_oe_d  = 1'b1;
        we_n_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // odd X keeps the word captured for the even X before it
  always_comb begin
    word_d = (op_q == OP_READ) ? iSRAM_DQ : word_q;
    red_d  = '0;
    grn_d  = '0;
    blu_d  = '0;
    if (s2_act_q) begin
      red_d = {word_q[15:11], word_q[15:11]};
      grn_d = {word_q[10:5], word_q[10:7]};
      blu_d = {word_q[4:0], word_q[4:0]};
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      op_q     <= OP_IDLE;
      addr_q   <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ce_n_q   <= 1'b1;
      s1_act_q <= 1'b0;
      s2_act_q <= 1'b0;
      word_q   <= '0;
      red_q    <= '0;
      grn_q    <= '0;
      blu_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ce_n_q   <= 1'b0;
      s1_act_q <= iActive;
      s2_act_q <= s1_act_q;
      word_q   <= word_d;
      red_q    <= red_d;
      grn_q    <= grn_d;
      blu_q    <= blu_d;
    end
  end

  // storage needs no reset; the count alone marks it empty
  always_ff @(posedge iCLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= iWr_Addr;
      fifo_data_q[wr_ptr_q] <= iWr_Data;
    end
  end

  assign oWr_Ack      = ack_q;
  assign oRed         = red_q;
  assign oGreen       = grn_q;
  assign oBlue        = blu_q;
  assign oSRAM_ADDR   = addr_q;
  assign oSRAM_DQ_OUT = dq_out_q;
  assign oSRAM_DQ_OE  = dq_oe_q;
  assign oSRAM_CE_N   = ce_n_q;
  assign oSRAM_OE_N   = oe_n_q;
  assign oSRAM_WE_N   = we_n_q;
  assign oSRAM_UB_N   = 1'b0;
  assign oSRAM_LB_N   = 1'b0;

endmodule

// File: tb/tb_vga_fb_fetch.sv
// tb_vga_fb_fetch: bench for vga_fb_fetch with an SRAM model,
// a reference frame buffer and randomized display/host traffic.

module tb_vga_fb_fetch;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [9:0]  iCoord_X, iCoord_Y;
  logic        iActive;
  logic        iWr_Req;
  logic [17:0] iWr_Addr;
  logic [15:0] iWr_Data;
  logic        oWr_Ack;
  logic [9:0]  oRed, oGreen, oBlue;
  logic [17:0] oSRAM_ADDR;
  logic [15:0] oSRAM_DQ_OUT;
  logic        oSRAM_DQ_OE;
  logic [15:0] iSRAM_DQ;
  logic        oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N;
  logic        oSRAM_UB_N, oSRAM_LB_N;

  vga_fb_fetch dut (
    .iCLK(iCLK), .iRST(iRST),
    .iCoord_X(iCoord_X), .iCoord_Y(iCoord_Y), .iActive(iActive),
    .iWr_Req(iWr_Req), .iWr_Addr(iWr_Addr), .iWr_Data(iWr_Data),
    .oWr_Ack(oWr_Ack),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oSRAM_ADDR(oSRAM_ADDR), .oSRAM_DQ_OUT(oSRAM_DQ_OUT),
    .oSRAM_DQ_OE(oSRAM_DQ_OE), .iSRAM_DQ(iSRAM_DQ),
    .oSRAM_CE_N(oSRAM_CE_N), .oSRAM_OE_N(oSRAM_OE_N),
    .oSRAM_WE_N(oSRAM_WE_N), .oSRAM_UB_N(oSRAM_UB_N),
    .oSRAM_LB_N(oSRAM_LB_N)
  );

  always #5 iCLK = ~iCLK;

  logic [15:0] mem    [0:262143];
  logic [15:0] ref_fb [0:262143];

  assign iSRAM_DQ = !oSRAM_OE_N ? mem[oSRAM_ADDR] : 16'h0;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int oor_we = 0;
  int we_cnt = 0;
  int ack_total = 0;
  int enq_total = 0;
  bit prev_rd = 1'b0;
  int prev_addr = 0;

  logic [17:0] wq_a [$];
  logic [15:0] wq_d [$];
  logic [17:0] log_a [$];
  logic [29:0] rgb_q [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] px(input logic [15:0] w);
    int r, g, b;
    r = int'(w[15:11]);
    g = int'(w[10:5]);
    b = int'(w[4:0]);
    return {10'(r * 33), 10'(g * 16 + g / 4), 10'(b * 33)};
  endfunction

  task automatic host_wr(input logic [17:0] a, input logic [15:0] d);
    wq_a.push_back(a);
    wq_d.push_back(d);
    log_a.push_back(a);
    enq_total++;
  endtask

  // one pixel clock: check outputs, model SRAM/host, drive inputs
  task automatic step(input int x, input int y, input bit act);
    logic [29:0] e;
    logic [17:0] a;
    logic [15:0] d;
    int ea;
    @(negedge iCLK);
    if (rgb_q.size() >= 3) begin
      e = rgb_q.pop_front();
      chk("rgb", 32'({oRed, oGreen, oBlue}), 32'(e));
    end
    if (prev_rd) begin
      chk("rd_addr", 32'(oSRAM_ADDR), 32'(prev_addr));
      chk("rd_oe_n", 32'(oSRAM_OE_N), 32'd0);
    end
    if (!oSRAM_WE_N) begin
      we_cnt++;
      if (prev_rd || !oSRAM_OE_N || !oSRAM_DQ_OE) viol++;
      if (oSRAM_ADDR >= 18'd76800) oor_we++;
      mem[oSRAM_ADDR] = oSRAM_DQ_OUT;
    end
    if (oWr_Ack) begin
      if (wq_a.size() == 0) viol++;
      else begin
        a = wq_a.pop_front();
        d = wq_d.pop_front();
        if (a < 18'd76800) ref_fb[a] = d;
        ack_total++;
      end
    end
    iWr_Req = (wq_a.size() != 0);
    if (iWr_Req) begin
      iWr_Addr = wq_a[0];
      iWr_Data = wq_d[0];
    end
    iCoord_X = 10'(x);
    iCoord_Y = 10'(y);
    iActive  = act;
    ea = (y / 2) * 320 + x / 2;
    rgb_q.push_back(act ? px(ref_fb[ea]) : 30'd0);
    prev_rd   = act && (x % 2 == 0);
    prev_addr = ea;
  endtask

  task automatic set_word(input int a, input logic [15:0] v);
    mem[a]    = v;
    ref_fb[a] = v;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_we"}, 32'(oSRAM_WE_N), 32'd1);
    chk({tag, "_oe"}, 32'(oSRAM_OE_N), 32'd1);
    chk({tag, "_ce"}, 32'(oSRAM_CE_N), 32'd1);
    chk({tag, "_dqoe"}, 32'(oSRAM_DQ_OE), 32'd0);
    chk({tag, "_ack"}, 32'(oWr_Ack), 32'd0);
    chk({tag, "_rgb"}, 32'({oRed, oGreen, oBlue}), 32'd0);
  endtask

  initial begin
    int base_ack, base_we;
    iRST = 1'b0;
    iCoord_X = '0;
    iCoord_Y = '0;
    iActive = 1'b0;
    iWr_Req = 1'b0;
    iWr_Addr = '0;
    iWr_Data = '0;
    for (int i = 0; i < 262144; i++) begin
      mem[i] = 16'h0;
      ref_fb[i] = 16'h0;
    end
    for (int i = 0; i < 38400; i++) set_word(i, 16'($urandom));

    // reset state
    #2 iRST = 1'b1;
    #1 chk_reset_outs("rst0");
    chk("rst0_addr", 32'(oSRAM_ADDR), 32'd0);
    chk("rst0_ub", 32'(oSRAM_UB_N), 32'd0);
    chk("rst0_lb", 32'(oSRAM_LB_N), 32'd0);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
    chk("ce_after_rst", 32'(oSRAM_CE_N), 32'd0);

    // read timing
    set_word(1610, 16'hF800);
    step(20, 10, 1);
    step(21, 10, 1);
    repeat (3) step(0, 0, 0);

    // RGB565 expansion
    set_word(3200, 16'h07E0);
    set_word(3201, 16'h001F);
    set_word(3202, 16'h8410);
    for (int x = 0; x < 6; x++) step(x, 20, 1);
    repeat (3) step(0, 0, 0);

    // writes interleaved with an active line
    for (int i = 0; i < 4; i++) host_wr(18'(100 + i), 16'(16'hAAAA + i));
    for (int x = 0; x < 64; x++) step(x, 10, 1);
    repeat (10) step(0, 0, 0);

    // FIFO full with only read slots
    base_ack = ack_total;
    for (int i = 0; i < 6; i++) host_wr(18'(200 + i), 16'($urandom));
    repeat (12) step(0, 0, 1);
    chk("full_acks", 32'(ack_total - base_ack), 32'd4);
    base_ack = ack_total;
    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("pop_then_ack", 32'(ack_total - base_ack), 32'd1);
    repeat (30) step(0, 0, 0);

    // blanking: every slot free, one out-of-range write
    base_ack = ack_total;
    base_we = we_cnt;
    for (int i = 0; i < 5; i++) host_wr(18'(300 + i), 16'($urandom));
    host_wr(18'd76800, 16'h1234);
    repeat (12) step(0, 0, 0);
    chk("blank_acks", 32'(ack_total - base_ack), 32'd6);
    repeat (4) step(0, 0, 0);
    chk("blank_we", 32'(we_cnt - base_we), 32'd5);

    // random display pairs with random host traffic
    for (int p = 0; p < 200; p++) begin
      int x, y;
      bit act;
      y = int'($urandom_range(0, 239));
      x = 2 * int'($urandom_range(0, 319));
      act = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && wq_a.size() < 6) begin
        if ($urandom_range(0, 9) == 0)
          host_wr(18'(76800 + $urandom_range(0, 999)), 16'($urandom));
        else
          host_wr(18'($urandom_range(40000, 76799)), 16'($urandom));
      end
      step(x, y, act);
      step(x + 1, y, act);
    end
    repeat (40) step(0, 0, 0);

    // display readback of the interleaved writes
    for (int x = 200; x < 208; x++) step(x, 0, 1);
    repeat (3) step(0, 0, 0);

    chk("no_overlap", 32'(viol), 32'd0);
    chk("oor_we", 32'(oor_we), 32'd0);
    chk("ack_total", 32'(ack_total), 32'(enq_total));
    foreach (log_a[i]) chk("mem", 32'(mem[log_a[i]]), 32'(ref_fb[log_a[i]]));

    // reset in the middle of a write
    for (int i = 0; i < 4; i++) host_wr(18'(500 + i), 16'($urandom));
    repeat (3) step(0, 0, 0);
    chk("we_before_rst", 32'(oSRAM_WE_N), 32'd0);
    #2 iRST = 1'b1;
    #1 chk_reset_outs("rst1");
    wq_a.delete();
    wq_d.delete();
    rgb_q.delete();
    prev_rd = 1'b0;
    iWr_Req = 1'b0;
    iActive = 1'b0;
    @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
    chk("ce_after_rst1", 32'(oSRAM_CE_N), 32'd0);
    step(20, 10, 1);
    step(21, 10, 1);
    repeat (4) step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
